mul_column_gather: RTL

MUL_COLUMN_GATHER -- requirements
Module: mul_column_gather

---
 rtl/mul_column_gather_pkg.sv | 14 +
 rtl/mul_add_half.sv | 87 ++++++++
 rtl/mul_column_gather.sv | 100 ++++++++++
 3 files changed

// File: rtl/mul_column_gather_pkg.sv
// -----------------------------------------------------------------------------
// mul_column_gather_pkg
// Shared constants for the integer multiplier datapath.
//   MUL_W        : product / Wallace column width
//   MUL_HW       : width of the low half of the final carry-propagate add
//   MUL_PP_COUNT : number of Booth partial products fed to the Wallace tree
// -----------------------------------------------------------------------------
package mul_column_gather_pkg;

   localparam int MUL_W        = 64;
   localparam int MUL_HW       = 32;
   localparam int MUL_PP_COUNT = 17;

endpackage : mul_column_gather_pkg

// File: rtl/mul_add_half.sv
// -----------------------------------------------------------------------------
// mul_add_half
// One registered pipeline stage of the split final adder. Computes
// a_i + b_i + ci_i, registers the HW-bit sum and its carry-out, and carries an
// untouched side payload alongside so the other half of the add can follow.
// Valid/ready handshake on both sides; flush clears the valid bit and blocks
// acceptance. Data registers are never reset, only the valid bit is.
// Ports:
//   clk, resetn             clock, async active-low reset
//   flush_i                 drop the stage contents, refuse input
//   in_valid_i / in_ready_o upstream handshake
//   a_i, b_i, ci_i          adder operands and carry-in
//   pass_i                  payload captured with the operands
//   out_valid_o/out_ready_i downstream handshake
//   sum_o, co_o, pass_o     registered sum, carry-out and payload
// -----------------------------------------------------------------------------
module mul_add_half #(
   parameter int HW = 32,
   parameter int PW = 64
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          flush_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [HW-1:0] a_i,
   input  logic [HW-1:0] b_i,
   input  logic          ci_i,
   input  logic [PW-1:0] pass_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [HW-1:0] sum_o,
   output logic          co_o,
   output logic [PW-1:0] pass_o
);

   logic          valid_q;
   logic          valid_d;
   logic          accept_s;
   logic [HW:0]   add_s;
   logic [HW-1:0] sum_q;
   logic          co_q;
   logic [PW-1:0] pass_q;

   // Stage can take new data when empty or when its content leaves this cycle.
   assign in_ready_o = (!valid_q || out_ready_i) && !flush_i;
   assign accept_s   = in_valid_i && in_ready_o;
   assign add_s      = {1'b0, a_i} + {1'b0, b_i} + {{HW{1'b0}}, ci_i};

   // Next-state of the valid bit: flush wins, then accept, then drain.
   always_comb begin
      valid_d = valid_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (accept_s) begin
         valid_d = 1'b1;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Valid bit register, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Data registers load only on accept; neither reset nor flush touches them.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         sum_q  <= add_s[HW-1:0];
         co_q   <= add_s[HW];
         pass_q <= pass_i;
      end
   end

   assign out_valid_o = valid_q;
   assign sum_o       = sum_q;
   assign co_o        = co_q;
   assign pass_o      = pass_q;

endmodule : mul_add_half

// File: rtl/mul_column_gather.sv
// -----------------------------------------------------------------------------
// mul_column_gather
// Reassembles the Wallace-tree column outputs into two rows and performs the
// final carry-propagate add in two pipelined halves:
//   stage 1: low half  = row_a[HW-1:0] + row_b[HW-1:0] + cin, high operands kept
//   stage 2: high half = hi_a + hi_b + c1, low half carried along
// Ports:
//   clk, resetn           clock, async active-low reset
//   in_valid / in_ready   input handshake for col_sum, col_carry, cin
//   col_sum, col_carry    per-column sum and carry bits (carry weight 2^(i+1))
//   cin                   Booth correction carry-in, weight 2^0
//   flush                 discard every in-flight operation
//   out_valid / out_ready result handshake
//   result                product modulo 2^W
// -----------------------------------------------------------------------------
module mul_column_gather
   import mul_column_gather_pkg::*;
#(
   parameter int W  = MUL_W,
   parameter int HW = W / 2
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] col_sum,
   input  logic [W-1:0] col_carry,
   input  logic         cin,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] result
);

   localparam int HI_W = W - HW;

   logic [W-1:0]      row_a_s;
   logic [W-1:0]      row_b_s;
   logic              unused_carry_top_s;

   logic              s1_valid_s;
   logic              s2_ready_s;
   logic [HW-1:0]     s1_lo_s;
   logic              s1_c1_s;
   logic [2*HI_W-1:0] s1_hi_s;

   logic [HI_W-1:0]   s2_hi_s;
   logic              s2_carry_unused_s;
   logic [HW-1:0]     s2_lo_s;

   // Carry of column i has weight 2^(i+1); the top column carry falls off mod 2^W.
   assign row_a_s            = col_sum;
   assign row_b_s            = {col_carry[W-2:0], 1'b0};
   assign unused_carry_top_s = col_carry[W-1];

   mul_add_half #(
      .HW (HW),
      .PW (2*HI_W)
   ) u_stage_lo (
      .clk         (clk),
      .resetn      (resetn),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .a_i         (row_a_s[HW-1:0]),
      .b_i         (row_b_s[HW-1:0]),
      .ci_i        (cin),
      .pass_i      ({row_a_s[W-1:HW], row_b_s[W-1:HW]}),
      .out_valid_o (s1_valid_s),
      .out_ready_i (s2_ready_s),
      .sum_o       (s1_lo_s),
      .co_o        (s1_c1_s),
      .pass_o      (s1_hi_s)
   );

   // High half consumes the registered half-carry; its own carry-out is the
   // bit beyond 2^W and is discarded.
   mul_add_half #(
      .HW (HI_W),
      .PW (HW)
   ) u_stage_hi (
      .clk         (clk),
      .resetn      (resetn),
      .flush_i     (flush),
      .in_valid_i  (s1_valid_s),
      .in_ready_o  (s2_ready_s),
      .a_i         (s1_hi_s[2*HI_W-1:HI_W]),
      .b_i         (s1_hi_s[HI_W-1:0]),
      .ci_i        (s1_c1_s),
      .pass_i      (s1_lo_s),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .sum_o       (s2_hi_s),
      .co_o        (s2_carry_unused_s),
      .pass_o      (s2_lo_s)
   );

   assign result = {s2_hi_s, s2_lo_s};

endmodule : mul_column_gather
